pwm_decoder: RTL

//  Receive side of the servo PWM link: measures the high time of an incoming
//  PWM frame and recovers the 2-bit position code that drove it.
//  - Frame: 20 ms period; high time 1.0/1.33/1.67/2.0 ms selects pos 0..3.
//  - Flags out-of-range pulses and a lost signal; reports link lock.
//  - Sits at the input pin, on the same 50 MHz clk as the pwm generator.

---
 rtl/pwm_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_decoder.sv
// Servo PWM receiver: measures the high time of each frame on pwm_in and
// recovers the 2-bit position code, with range, timeout and lock reporting.
`timescale 1ns/1ps
module pwm_decoder #(
    parameter int CNT_W       = 21,
    parameter int TH01        = 58333,
    parameter int TH12        = 75000,
    parameter int TH23        = 91667,
    parameter int MIN_HIGH    = 25000,
    parameter int MAX_HIGH    = 125000,
    parameter int TIMEOUT_CYC = 1250000,
    parameter int LOCK_CNT    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [1:0] pos,
    output logic       valid,
    output logic       err_range,
    output logic       err_timeout,
    output logic       locked
);

    localparam int LOCK_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  H_SAT     = CNT_W'(MAX_HIGH + 1);
    localparam logic [CNT_W-1:0]  H_MIN     = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0]  H_MAX     = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0]  T_SAT     = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  T_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CNT);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
    localparam int                TH_TAB [3] = '{TH01, TH12, TH23};

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        LOW      = 2'd1,
        HIGH     = 2'd2
    } state_t;

    state_t            state_reg;
    logic              sync1_reg;
    logic              s_reg;
    logic              s_dly_reg;
    logic [1:0]        fill_reg;
    logic [CNT_W-1:0]  hcnt_reg;
    logic [CNT_W-1:0]  tcnt_reg;
    logic              done_reg;
    logic              legal_reg;
    logic [1:0]        code_reg;
    logic [LOCK_W-1:0] lock_cnt_reg;
    logic [1:0]        pos_reg;
    logic              valid_reg;
    logic              err_range_reg;
    logic              err_timeout_reg;
    logic              locked_reg;

    logic              rise;
    logic              timeout_evt;
    logic              legal_w;
    logic [1:0]        code_w;
    logic [2:0]        ge_th;
    logic [LOCK_W-1:0] lock_next;

    assign rise        = s_reg & ~s_dly_reg;
    assign timeout_evt = ~rise && (tcnt_reg == T_LAST);

    // The code is the number of thresholds the width has reached, so an
    // exact boundary value lands on the higher code.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_th
            assign ge_th[gi] = (hcnt_reg >= CNT_W'(TH_TAB[gi]));
        end
    endgenerate

    assign code_w    = 2'(ge_th[0]) + 2'(ge_th[1]) + 2'(ge_th[2]);
    assign legal_w   = (hcnt_reg >= H_MIN) && (hcnt_reg <= H_MAX);
    assign lock_next = (lock_cnt_reg == LOCK_MAX) ? LOCK_MAX : lock_cnt_reg + LOCK_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= WAIT_LOW;
            sync1_reg       <= 1'b0;
            s_reg           <= 1'b0;
            s_dly_reg       <= 1'b0;
            fill_reg        <= 2'd0;
            hcnt_reg        <= '0;
            tcnt_reg        <= '0;
            done_reg        <= 1'b0;
            legal_reg       <= 1'b0;
            code_reg        <= 2'd0;
            lock_cnt_reg    <= '0;
            pos_reg         <= 2'd0;
            valid_reg       <= 1'b0;
            err_range_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
            locked_reg      <= 1'b0;
        end else begin
            sync1_reg <= pwm_in;
            s_reg     <= sync1_reg;
            s_dly_reg <= s_reg;

            // s is only trustworthy once the synchroniser has refilled after reset
            if (fill_reg != 2'd2)
                fill_reg <= fill_reg + 2'd1;

            if (rise)
                tcnt_reg <= '0;
            else if (tcnt_reg != T_SAT)
                tcnt_reg <= tcnt_reg + CNT_W'(1);

            done_reg <= 1'b0;
            case (state_reg)
                WAIT_LOW: begin
                    if (fill_reg == 2'd2 && !s_reg)
                        state_reg <= LOW;
                end
                LOW: begin
                    if (rise) begin
                        state_reg <= HIGH;
                        hcnt_reg  <= CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (timeout_evt) begin
                        state_reg <= WAIT_LOW;
                    end else if (s_reg) begin
                        if (hcnt_reg != H_SAT)
                            hcnt_reg <= hcnt_reg + CNT_W'(1);
                    end else begin
                        state_reg <= LOW;
                        done_reg  <= 1'b1;
                        legal_reg <= legal_w;
                        code_reg  <= code_w;
                    end
                end
                default: state_reg <= WAIT_LOW;
            endcase

            valid_reg     <= 1'b0;
            err_range_reg <= 1'b0;
            if (timeout_evt) begin
                err_timeout_reg <= 1'b1;
                lock_cnt_reg    <= '0;
                locked_reg      <= 1'b0;
            end else if (done_reg) begin
                if (legal_reg) begin
                    pos_reg         <= code_reg;
                    valid_reg       <= 1'b1;
                    err_timeout_reg <= 1'b0;
                    lock_cnt_reg    <= lock_next;
                    locked_reg      <= (lock_next == LOCK_MAX);
                end else begin
                    err_range_reg <= 1'b1;
                    lock_cnt_reg  <= '0;
                    locked_reg    <= 1'b0;
                end
            end
        end
    end

    assign pos         = pos_reg;
    assign valid       = valid_reg;
    assign err_range   = err_range_reg;
    assign err_timeout = err_timeout_reg;
    assign locked      = locked_reg;

endmodule
